req_latch_encoder: RTL and testbench

- Upstream request-capture stage for the 4-to-2 encoder path.
- Latches single-cycle request pulses from NREQ sources into a pending register.
- Presents one encoded index at a time on a valid/ready handshake.
- Clears each pending bit once its index is accepted, so bursty one-hot or multi-hot pulses are never lost.

---
 rtl/req_enc_pkg.sv | 24 ++
 rtl/req_latch_encoder_prio_enc.sv | 32 +++
 rtl/req_latch_encoder.sv | 131 +++++++++++++
 tb/tb_req_latch_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// Shared types and helpers for the request-latch / encoder path.
package req_enc_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int CODE_W_DEF = 2;

  // Widest request vector the onehot helper can decode.
  localparam int ONEHOT_W  = 32;
  localparam int ONEHOT_CW = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Decodes an index into a one-hot vector; callers truncate to their width.
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_CW-1:0] code);
    logic [ONEHOT_W-1:0] r;
    r       = '0;
    r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/req_latch_encoder_prio_enc.sv
// Priority encoder with a movable start point.
// Scans downward from start_i with wrap-around and reports the first set bit.
// With start_i tied to NREQ-1 this is a plain highest-index-wins encoder.
module prio_enc
  import req_enc_pkg::*;
#(
  parameter int  NREQ   = NREQ_DEF,
  localparam int CODE_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]   vec_i,
  input  logic [CODE_W-1:0] start_i,
  output logic [CODE_W-1:0] code_o,
  output logic              found_o
);

  logic [CODE_W-1:0] idx;

  // Downward wrapping search; the index arithmetic wraps because NREQ is a power of two.
  always_comb begin
    code_o  = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = start_i - CODE_W'(i);
      if (!found_o && vec_i[idx]) begin
        code_o  = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_latch_encoder.sv
// Request-capture stage: latches single-cycle request pulses into a pending
// register and presents one encoded index at a time on a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid_o && ready_i.
// While valid_o is high and ready_i is low, code_o is held stable. valid_o
// does not depend combinationally on ready_i.
//
// Optional build macro REQ_LATCH_ROUND_ROBIN_EN: rotating priority that starts
// the search one below the last granted index. Undefined: fixed
// highest-index-wins priority.
module req_latch_encoder
  import req_enc_pkg::*;
#(
  parameter int  NREQ   = NREQ_DEF,
  localparam int CODE_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [NREQ-1:0]   pending_o,
  output logic              overrun_o
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   pending_q, pending_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              overrun_q, overrun_d;

  logic              handshake;
  logic [NREQ-1:0]   served;
  logic [NREQ-1:0]   pick_vec;
  logic [CODE_W-1:0] pick_start;
  logic [CODE_W-1:0] pick_code;
  logic              pick_found;

  assign valid_o   = (state_q == HOLD);
  assign code_o    = code_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

  assign handshake = valid_o && ready_i;
  assign served    = handshake ? NREQ'(onehot(ONEHOT_CW'(code_q))) : '0;

  // Set wins over clear: a re-request of the served bit stays pending.
  assign pending_d = (pending_q & ~served) | req_i;
  assign overrun_d = |(req_i & pending_q & ~served);

  // In HOLD the next code comes from what remains after this cycle's update;
  // in IDLE it comes from the current pending register.
  assign pick_vec = (state_q == HOLD) ? pending_d : pending_q;

`ifdef REQ_LATCH_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_code_q, last_code_d;

  // On a handshake the code being accepted becomes the new last grant.
  assign last_code_d = handshake ? code_q : last_code_q;
  assign pick_start  = last_code_d - CODE_W'(1);

  // Last-granted index register for the rotating search.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_code_q <= '0;
    end else begin
      last_code_q <= last_code_d;
    end
  end
`else
  assign pick_start = CODE_W'(NREQ - 1);
`endif

  prio_enc #(
    .NREQ (NREQ)
  ) u_prio_enc (
    .vec_i   (pick_vec),
    .start_i (pick_start),
    .code_o  (pick_code),
    .found_o (pick_found)
  );

  // Next-state and code-load logic for the IDLE/HOLD grant machine.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          code_d  = pick_code;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          if (pick_found) begin
            code_d = pick_code;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending, presented code and overrun pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      code_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_req_latch_encoder.sv
// Directed bench for req_latch_encoder. Expected grants are queued when the
// requests are driven and popped whenever a handshake is observed.
// Honours REQ_LATCH_ROUND_ROBIN_EN for the rotating-priority expectations.
module tb_req_latch_encoder;

  localparam int NREQ   = 4;
  localparam int CODE_W = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_i;
  logic [CODE_W-1:0] code_o;
  logic              valid_o;
  logic              ready_i;
  logic [NREQ-1:0]   pending_o;
  logic              overrun_o;

  logic [CODE_W-1:0] exp_q[$];
  int                n_cmp;
  int                n_err;

  req_latch_encoder #(
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .pending_o (pending_o),
    .overrun_o (overrun_o)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req_i   = 4'hF;
    ready_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    req_i = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((valid_o || pending_o != '0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(valid_o || (pending_o != '0)), 32'd0);
    check("drain_q", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every handshake must match the oldest queued grant.
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      check("grant_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("grant", 32'(code_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Directed stimulus
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    req_i   = '0;
    ready_i = 1'b0;

    // Reset with requests asserted
    do_reset();
    check("rst_pending", 32'(pending_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_code", 32'(code_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    tick();
    check("rst_pending_post", 32'(pending_o), 32'h0);
    check("rst_valid_post", 32'(valid_o), 32'd0);

    // Single request, two-edge latency
    ready_i = 1'b1;
    exp_q.push_back(2'd2);
    req_i = 4'b0100;
    tick();
    req_i = '0;
    check("single_pending", 32'(pending_o), 32'h4);
    check("single_valid_early", 32'(valid_o), 32'd0);
    tick();
    check("single_valid", 32'(valid_o), 32'd1);
    check("single_code", 32'(code_o), 32'd2);
    tick();
    check("single_pending_clr", 32'(pending_o), 32'h0);
    check("single_valid_drop", 32'(valid_o), 32'd0);
    check("single_q", 32'(exp_q.size()), 32'd0);

    // Multi-hot burst, back-to-back grants in priority order
    do_reset();
    ready_i = 1'b1;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    req_i = 4'hF;
    tick();
    req_i = '0;
    check("burst_pending", 32'(pending_o), 32'hF);
    tick();
    check("burst_code3", 32'(code_o), 32'd3);
    tick();
    check("burst_code2", 32'(code_o), 32'd2);
    check("burst_pending2", 32'(pending_o), 32'h7);
    tick();
    check("burst_code1", 32'(code_o), 32'd1);
    tick();
    check("burst_code0", 32'(code_o), 32'd0);
    check("burst_valid0", 32'(valid_o), 32'd1);
    tick();
    check("burst_valid_drop", 32'(valid_o), 32'd0);
    check("burst_pending_clr", 32'(pending_o), 32'h0);
    wait_idle(10);

    // Backpressure holds the presented code
    do_reset();
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    req_i = 4'b1010;
    tick();
    req_i = '0;
    tick();
    check("bp_valid", 32'(valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_code", 32'(code_o), 32'd3);
      check("bp_hold_valid", 32'(valid_o), 32'd1);
    end
    check("bp_pending", 32'(pending_o), 32'hA);
    ready_i = 1'b1;
    tick();
    check("bp_code1", 32'(code_o), 32'd1);
    check("bp_pending1", 32'(pending_o), 32'h2);
    tick();
    check("bp_valid_drop", 32'(valid_o), 32'd0);
    wait_idle(10);

    // Overrun on an unserved pending bit
    do_reset();
    exp_q.push_back(2'd1);
    req_i = 4'b0010;
    tick();
    req_i = '0;
    check("ov_none_first", 32'(overrun_o), 32'd0);
    tick();
    check("ov_code", 32'(code_o), 32'd1);
    req_i = 4'b0010;
    tick();
    req_i = '0;
    check("ov_pulse", 32'(overrun_o), 32'd1);
    check("ov_pending", 32'(pending_o), 32'h2);
    tick();
    check("ov_pulse_end", 32'(overrun_o), 32'd0);
    ready_i = 1'b1;
    wait_idle(10);

    // Set wins over clear on the served bit
    do_reset();
    exp_q.push_back(2'd3);
    req_i = 4'b1000;
    tick();
    req_i = '0;
    tick();
    check("sw_code", 32'(code_o), 32'd3);
    ready_i = 1'b1;
    req_i   = 4'b1000;
    exp_q.push_back(2'd3);
    tick();
    req_i = '0;
    check("sw_overrun", 32'(overrun_o), 32'd0);
    check("sw_pending", 32'(pending_o), 32'h8);
    check("sw_valid", 32'(valid_o), 32'd1);
    check("sw_code_again", 32'(code_o), 32'd3);
    tick();
    check("sw_valid_drop", 32'(valid_o), 32'd0);
    wait_idle(10);

    // Reset mid-handshake drops the in-flight code
    do_reset();
    req_i = 4'b0100;
    tick();
    req_i = '0;
    tick();
    check("mr_valid_before", 32'(valid_o), 32'd1);
    do_reset();
    check("mr_valid", 32'(valid_o), 32'd0);
    check("mr_pending", 32'(pending_o), 32'h0);
    check("mr_code", 32'(code_o), 32'd0);

    // Sustained re-requests of bits 3 and 1
    do_reset();
    ready_i = 1'b1;
`ifdef REQ_LATCH_ROUND_ROBIN_EN
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
`else
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
`endif
    req_i = 4'b1010;
    repeat (6) tick();
    req_i = '0;
    wait_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
